id_issue_unit: RTL and testbench

Decode-and-issue front end that drives the ID/EX pipeline register. It holds one fetched instruction, reads the 8x32 register file, and tracks outstanding register writes with a scoreboard. It issues the instruction's control bits, operand data and destination address into ID/EX, or inserts a bubble on a RAW/WAW hazard or a downstream stall. It also owns the writeback port of the register file, closing the loop from the end of the pipeline.

---
 rtl/id_issue_if.sv | 40 ++++
 rtl/id_issue_unit.sv | 126 ++++++++++++
 tb/tb_id_issue_unit.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/id_issue_if.sv
`default_nettype none
// ============================================================================
// Module   : id_issue_if
// Purpose  : Fetch, writeback and ID/EX signal bundle for id_issue_unit.
// Revision : 1.0 - initial release
// ============================================================================
interface id_issue_if #(
  parameter int data_width = 32,
  parameter int reg_addr   = 3,
  parameter int cnt_width  = 16
);
  logic                  instr_valid;
  logic [31:0]           instr;
  logic                  instr_ready;
  logic                  ex_stall;
  logic                  wb_en;
  logic [reg_addr-1:0]   wb_addr;
  logic [data_width-1:0] wb_data;
  logic                  WRegEn_out;
  logic                  WMemEn_out;
  logic [data_width-1:0] r1_data_out;
  logic [data_width-1:0] r2_data_out;
  logic [reg_addr-1:0]   wReg1_out;
  logic                  idex_enable;
  logic [cnt_width-1:0]  issue_cnt;
  logic [cnt_width-1:0]  stall_cnt;

  modport master (
    output instr_valid, instr, ex_stall, wb_en, wb_addr, wb_data,
    input  instr_ready, WRegEn_out, WMemEn_out, r1_data_out, r2_data_out,
           wReg1_out, idex_enable, issue_cnt, stall_cnt
  );

  modport slave (
    input  instr_valid, instr, ex_stall, wb_en, wb_addr, wb_data,
    output instr_ready, WRegEn_out, WMemEn_out, r1_data_out, r2_data_out,
           wReg1_out, idex_enable, issue_cnt, stall_cnt
  );
endinterface
`default_nettype wire

// File: rtl/id_issue_unit.sv
`default_nettype none
// ============================================================================
// Module   : id_issue_unit
// Purpose  : Decode/issue stage with register file, scoreboard and ID/EX feed.
// Revision : 1.0 - initial release
// ============================================================================
module id_issue_unit #(
  parameter int data_width = 32,
  parameter int reg_addr   = 3,
  parameter int cnt_width  = 16
) (
  input  logic      clk,
  input  logic      reset,
  id_issue_if.slave bus
);
  localparam int c_nreg = 1 << reg_addr;

  // Only the control and register-index bits of the instruction are kept.
  logic [31:21]          r_ir;
  logic                  r_ir_valid;
  logic [data_width-1:0] r_rf [c_nreg];
  logic [c_nreg-1:0]     r_pending;
  logic [cnt_width-1:0]  r_issue_cnt;
  logic [cnt_width-1:0]  r_stall_cnt;

  logic [reg_addr-1:0]   w_rs1;
  logic [reg_addr-1:0]   w_rs2;
  logic [reg_addr-1:0]   w_dst;
  logic [c_nreg-1:0]     w_wb_mask;
  logic [c_nreg-1:0]     w_eff_pend;
  logic [c_nreg-1:0]     w_set_mask;
  logic                  w_hazard;
  logic                  w_fire;
  logic                  w_accept;
  logic                  w_stall_evt;
  logic [data_width-1:0] w_rd1;
  logic [data_width-1:0] w_rd2;
  logic                  w_unused_instr;

  assign w_unused_instr = ^bus.instr[20:0];

  assign w_dst = r_ir[29 -: reg_addr];
  assign w_rs1 = r_ir[26 -: reg_addr];
  assign w_rs2 = r_ir[23 -: reg_addr];

  // A writeback in flight releases its register in the same cycle.
  assign w_wb_mask  = bus.wb_en ? (c_nreg'(1) << bus.wb_addr) : '0;
  assign w_eff_pend = r_pending & ~w_wb_mask;

  assign w_hazard    = r_ir_valid & (w_eff_pend[w_rs1] | w_eff_pend[w_rs2] |
                                     (r_ir[31] & w_eff_pend[w_dst]));
  assign w_fire      = r_ir_valid & ~w_hazard & ~bus.ex_stall;
  assign w_accept    = bus.instr_valid & (~r_ir_valid | w_fire);
  assign w_stall_evt = r_ir_valid & w_hazard & ~bus.ex_stall;
  assign w_set_mask  = (w_fire & r_ir[31]) ? (c_nreg'(1) << w_dst) : '0;

  assign w_rd1 = (bus.wb_en && bus.wb_addr == w_rs1) ? bus.wb_data : r_rf[w_rs1];
  assign w_rd2 = (bus.wb_en && bus.wb_addr == w_rs2) ? bus.wb_data : r_rf[w_rs2];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ir       <= '0;
      r_ir_valid <= 1'b0;
    end else if (w_accept) begin
      r_ir       <= bus.instr[31:21];
      r_ir_valid <= 1'b1;
    end else if (w_fire) begin
      r_ir_valid <= 1'b0;
    end
  end

  // Set after clear so a same-register issue keeps the new write outstanding.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pending <= '0;
    end else begin
      r_pending <= (r_pending & ~w_wb_mask) | w_set_mask;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < c_nreg; i++) begin
        r_rf[i] <= '0;
      end
    end else if (bus.wb_en) begin
      r_rf[bus.wb_addr] <= bus.wb_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_issue_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_fire && r_issue_cnt != '1) begin
        r_issue_cnt <= r_issue_cnt + cnt_width'(1);
      end
      if (w_stall_evt && r_stall_cnt != '1) begin
        r_stall_cnt <= r_stall_cnt + cnt_width'(1);
      end
    end
  end

  always_comb begin
    bus.instr_ready = ~r_ir_valid | w_fire;
    bus.idex_enable = ~bus.ex_stall;
    bus.issue_cnt   = r_issue_cnt;
    bus.stall_cnt   = r_stall_cnt;
    bus.WRegEn_out  = 1'b0;
    bus.WMemEn_out  = 1'b0;
    bus.r1_data_out = '0;
    bus.r2_data_out = '0;
    bus.wReg1_out   = '0;
    if (r_ir_valid) begin
      bus.r1_data_out = w_rd1;
      bus.r2_data_out = w_rd2;
      bus.wReg1_out   = w_dst;
    end
    if (w_fire) begin
      bus.WRegEn_out = r_ir[31];
      bus.WMemEn_out = r_ir[30];
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_id_issue_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_issue_unit
// Purpose  : Directed table plus randomized checking of id_issue_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_id_issue_unit;
  localparam int DW = 32;
  localparam int RA = 3;
  localparam int CW = 16;
  localparam int NR = 8;
  localparam logic [31:0] DB = 32'hDEADBEEF;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  id_issue_if #(.data_width(DW), .reg_addr(RA), .cnt_width(CW)) bus ();
  id_issue_unit #(.data_width(DW), .reg_addr(RA), .cnt_width(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Reference state: register values, outstanding writes, held instruction.
  logic [31:0] m_rf [NR];
  bit          m_busy [NR];
  bit          m_irv;
  logic [31:0] m_ir;
  int          m_issue;
  int          m_stall;

  logic        s_wr, s_wm, s_rdy, s_idex;
  logic [31:0] s_r1, s_r2;
  logic [2:0]  s_d;

  typedef struct {
    bit          vi;
    logic [31:0] ins;
    bit          st;
    bit          we;
    logic [2:0]  wa;
    logic [31:0] wd;
    bit          e_wr;
    bit          e_wm;
    logic [31:0] e_r1;
    logic [31:0] e_r2;
    logic [2:0]  e_d;
    bit          e_rdy;
    bit          e_idex;
  } vec_t;

  vec_t tbl [24];

  function automatic logic [31:0] enc(bit wr, bit wm, int d, int s1, int s2);
    return {wr, wm, d[2:0], s1[2:0], s2[2:0], 21'h0};
  endfunction

  function automatic vec_t mk(bit vi, logic [31:0] ins, bit st, bit we, int wa, logic [31:0] wd,
                              bit wr, bit wm, logic [31:0] r1, logic [31:0] r2, int d,
                              bit rdy, bit idex);
    vec_t v;
    v.vi = vi; v.ins = ins; v.st = st; v.we = we; v.wa = wa[2:0]; v.wd = wd;
    v.e_wr = wr; v.e_wm = wm; v.e_r1 = r1; v.e_r2 = r2; v.e_d = d[2:0];
    v.e_rdy = rdy; v.e_idex = idex;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NR; i++) begin
      m_rf[i] = '0;
      m_busy[i] = 1'b0;
    end
    m_irv = 1'b0; m_ir = '0; m_issue = 0; m_stall = 0;
  endtask

  function automatic bit busy_now(int r, bit we, logic [2:0] wa);
    return m_busy[r] && !(we && wa == r[2:0]);
  endfunction

  // Drive one cycle's inputs, check all outputs at the falling edge, advance the model.
  task automatic cycle(bit vi, logic [31:0] ins, bit st, bit we, logic [2:0] wa, logic [31:0] wd);
    int s1, s2, d;
    bit blocked, go, rdy;
    logic [31:0] v1, v2;
    bus.instr_valid = vi; bus.instr = ins; bus.ex_stall = st;
    bus.wb_en = we; bus.wb_addr = wa; bus.wb_data = wd;
    @(negedge clk);
    d  = m_ir[29:27];
    s1 = m_ir[26:24];
    s2 = m_ir[23:21];
    blocked = m_irv && (busy_now(s1, we, wa) || busy_now(s2, we, wa) ||
                        (m_ir[31] && busy_now(d, we, wa)));
    go  = m_irv && !blocked && !st;
    rdy = !m_irv || go;
    v1 = (we && wa == s1[2:0]) ? wd : m_rf[s1];
    v2 = (we && wa == s2[2:0]) ? wd : m_rf[s2];
    s_wr = bus.WRegEn_out; s_wm = bus.WMemEn_out; s_r1 = bus.r1_data_out;
    s_r2 = bus.r2_data_out; s_d = bus.wReg1_out; s_rdy = bus.instr_ready;
    s_idex = bus.idex_enable;
    chk("WRegEn_out",  32'(s_wr), 32'(go && m_ir[31]));
    chk("WMemEn_out",  32'(s_wm), 32'(go && m_ir[30]));
    chk("r1_data_out", s_r1, m_irv ? v1 : 32'h0);
    chk("r2_data_out", s_r2, m_irv ? v2 : 32'h0);
    chk("wReg1_out",   32'(s_d), m_irv ? 32'(d) : 32'h0);
    chk("instr_ready", 32'(s_rdy), 32'(rdy));
    chk("idex_enable", 32'(s_idex), 32'(!st));
    chk("issue_cnt",   32'(bus.issue_cnt), 32'(m_issue));
    chk("stall_cnt",   32'(bus.stall_cnt), 32'(m_stall));
    if (we) begin
      m_rf[wa] = wd;
      m_busy[wa] = 1'b0;
    end
    if (go && m_ir[31]) m_busy[d] = 1'b1;
    if (go && m_issue < 65535) m_issue++;
    if (blocked && !st && m_stall < 65535) m_stall++;
    if (vi && rdy) begin
      m_ir = ins;
      m_irv = 1'b1;
    end else if (go) begin
      m_irv = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(string tag);
    chk({tag, "_WRegEn"}, 32'(bus.WRegEn_out), 32'h0);
    chk({tag, "_WMemEn"}, 32'(bus.WMemEn_out), 32'h0);
    chk({tag, "_ready"},  32'(bus.instr_ready), 32'h1);
    chk({tag, "_idex"},   32'(bus.idex_enable), 32'h1);
    chk({tag, "_issue"},  32'(bus.issue_cnt), 32'h0);
    chk({tag, "_stall"},  32'(bus.stall_cnt), 32'h0);
    chk({tag, "_r1"},     bus.r1_data_out, 32'h0);
  endtask

  initial begin
    tbl[0]  = mk(0, 0,                 0, 1, 3, DB,       0, 0, 0,  0,        0, 1, 1);
    tbl[1]  = mk(1, enc(1, 0, 5, 3, 0), 0, 0, 0, 0,        0, 0, 0,  0,        0, 1, 1);
    tbl[2]  = mk(0, 0,                 0, 0, 0, 0,        1, 0, DB, 0,        5, 1, 1);
    tbl[3]  = mk(1, enc(0, 1, 1, 0, 5), 0, 0, 0, 0,        0, 0, 0,  0,        0, 1, 1);
    tbl[4]  = mk(0, 0,                 0, 0, 0, 0,        0, 0, 0,  0,        1, 0, 1);
    tbl[5]  = mk(0, 0,                 0, 0, 0, 0,        0, 0, 0,  0,        1, 0, 1);
    tbl[6]  = mk(0, 0,                 0, 1, 5, 32'h1234, 0, 1, 0,  32'h1234, 1, 1, 1);
    tbl[7]  = mk(1, enc(1, 0, 2, 0, 0), 0, 0, 0, 0,        0, 0, 0,  0,        0, 1, 1);
    tbl[8]  = mk(1, enc(1, 0, 2, 1, 1), 0, 0, 0, 0,        1, 0, 0,  0,        2, 1, 1);
    tbl[9]  = mk(0, 0,                 0, 0, 0, 0,        0, 0, 0,  0,        2, 0, 1);
    tbl[10] = mk(0, 0,                 0, 1, 2, 32'h55,   1, 0, 0,  0,        2, 1, 1);
    tbl[11] = mk(1, enc(0, 0, 0, 2, 2), 0, 0, 0, 0,        0, 0, 0,  0,        0, 1, 1);
    tbl[12] = mk(0, 0,                 0, 0, 0, 0,        0, 0, 32'h55, 32'h55, 0, 0, 1);
    tbl[13] = mk(0, 0,                 0, 1, 2, 32'h66,   0, 0, 32'h66, 32'h66, 0, 1, 1);
    tbl[14] = mk(1, enc(1, 1, 4, 3, 3), 0, 0, 0, 0,        0, 0, 0,  0,        0, 1, 1);
    tbl[15] = mk(0, 0,                 1, 0, 0, 0,        0, 0, DB, DB,       4, 0, 0);
    tbl[16] = mk(0, 0,                 1, 0, 0, 0,        0, 0, DB, DB,       4, 0, 0);
    tbl[17] = mk(0, 0,                 1, 0, 0, 0,        0, 0, DB, DB,       4, 0, 0);
    tbl[18] = mk(0, 0,                 0, 0, 0, 0,        1, 1, DB, DB,       4, 1, 1);
    tbl[19] = mk(1, enc(0, 1, 6, 3, 0), 0, 0, 0, 0,        0, 0, 0,  0,        0, 1, 1);
    tbl[20] = mk(1, enc(0, 1, 7, 0, 3), 0, 0, 0, 0,        0, 1, DB, 0,        6, 1, 1);
    tbl[21] = mk(1, enc(0, 1, 1, 3, 3), 0, 0, 0, 0,        0, 1, 0,  DB,       7, 1, 1);
    tbl[22] = mk(1, enc(0, 1, 3, 1, 0), 0, 0, 0, 0,        0, 1, DB, DB,       1, 1, 1);
    tbl[23] = mk(0, 0,                 0, 0, 0, 0,        0, 1, 0,  0,        3, 1, 1);

    reset = 1'b1;
    bus.instr_valid = 1'b0; bus.instr = '0; bus.ex_stall = 1'b0;
    bus.wb_en = 1'b0; bus.wb_addr = '0; bus.wb_data = '0;
    model_reset();
    #3;
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    reset = 1'b0;

    for (int i = 0; i < 24; i++) begin
      cycle(tbl[i].vi, tbl[i].ins, tbl[i].st, tbl[i].we, tbl[i].wa, tbl[i].wd);
      chk($sformatf("tbl%0d_WRegEn", i), 32'(s_wr),   32'(tbl[i].e_wr));
      chk($sformatf("tbl%0d_WMemEn", i), 32'(s_wm),   32'(tbl[i].e_wm));
      chk($sformatf("tbl%0d_r1", i),     s_r1,        tbl[i].e_r1);
      chk($sformatf("tbl%0d_r2", i),     s_r2,        tbl[i].e_r2);
      chk($sformatf("tbl%0d_wReg1", i),  32'(s_d),    32'(tbl[i].e_d));
      chk($sformatf("tbl%0d_ready", i),  32'(s_rdy),  32'(tbl[i].e_rdy));
      chk($sformatf("tbl%0d_idex", i),   32'(s_idex), 32'(tbl[i].e_idex));
    end
    chk("tbl_issue_total", 32'(bus.issue_cnt), 32'd10);
    chk("tbl_stall_total", 32'(bus.stall_cnt), 32'd4);

    for (int i = 0; i < 2000; i++) begin
      cycle($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 4) == 0,
            $urandom_range(0, 2) == 0, 3'($urandom_range(0, 7)), $urandom);
    end

    // Reset while a dependent instruction is held behind an outstanding write.
    bus.instr_valid = 1'b0; bus.ex_stall = 1'b0; bus.wb_en = 1'b0;
    reset = 1'b1;
    #2;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    cycle(1, enc(1, 0, 6, 0, 0), 0, 0, 0, 0);
    cycle(1, enc(0, 1, 0, 6, 6), 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    chk("midreset_held_stalled", 32'(s_rdy), 32'h0);
    bus.instr_valid = 1'b0; bus.wb_en = 1'b0; bus.ex_stall = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check_reset_outputs("midreset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    cycle(1, enc(0, 1, 0, 6, 6), 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    chk("post_reset_fire_WMemEn", 32'(s_wm), 32'h1);
    chk("post_reset_fire_r1",     s_r1, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
